decode_stage: RTL and testbench

Instruction decode and operand-issue stage that sits directly upstream of the execute-stage ALU. It accepts one fetched instruction per cycle over a valid/ready handshake and reads the register file. It resolves RAW hazards by forwarding or stalling, and registers a fully formed ALU command (op1, op2, opcode, funct3, funct7) plus writeback metadata for the execute stage. Memory and upper-immediate instructions are rewritten into ALU ADD commands, so the ALU only ever sees OP or OPIMM.

---
 rtl/core_pkg.sv | 36 +++
 rtl/decode_stage_if.sv | 36 +++
 rtl/imm_gen.sv | 21 ++
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared decode/ALU definitions: opcodes, funct codes, immediate kinds and the
// registered issue bundle handed to the execute stage.
package core_pkg;

    localparam int unsigned CoreXlen = 32;
    localparam int unsigned CoreNreg = 32;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Srx  = 3'b101;
    localparam logic [6:0] F7Zero = 7'b0000000;

    typedef enum logic [1:0] {ImmI, ImmS, ImmU} imm_type_e;

    typedef struct packed {
        logic [CoreXlen-1:0] op1;
        logic [CoreXlen-1:0] op2;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [6:0]          orig_opcode;
        logic [4:0]          rd;
        logic                wen;
        logic [CoreXlen-1:0] store_data;
        logic [CoreXlen-1:0] pc;
        logic                illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshakes of the decode stage.
// slave: the decode stage; master: its fetch/execute neighbours.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [6:0]      ex_orig_opcode;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, ex_valid, ex_op1, ex_op2, ex_opcode, ex_funct3, ex_funct7,
               ex_orig_opcode, ex_rd, ex_wen, ex_store_data, ex_pc, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, ex_valid, ex_op1, ex_op2, ex_opcode, ex_funct3, ex_funct7,
               ex_orig_opcode, ex_rd, ex_wen, ex_store_data, ex_pc, ex_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: I/S/U immediates sign-extended to XLEN.
module imm_gen
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CoreXlen
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);
    logic unused_opc;
    assign unused_opc = ^instr[6:0];

    always_comb begin
        case (imm_type)
            ImmS:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            ImmU:    imm = XLEN'($signed({instr[31:12], 12'b0}));
            default: imm = XLEN'($signed(instr[31:20]));
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Decode and operand-issue stage feeding the ALU. Define DECODE_FORWARD_EN to
// enable EX/MEM forwarding (load-use stall only); otherwise any RAW match stalls.
module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CoreXlen,
    parameter int unsigned NREG = CoreNreg,
    localparam int unsigned RegAw = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_if.slave    bus,
    output logic [RegAw-1:0] rf_rs1_addr,
    output logic [RegAw-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             fw_ex_wen,
    input  logic [RegAw-1:0] fw_ex_rd,
    input  logic [XLEN-1:0]  fw_ex_data,
    input  logic             fw_ex_is_load,
    input  logic             fw_mem_wen,
    input  logic [RegAw-1:0] fw_mem_rd,
    input  logic [XLEN-1:0]  fw_mem_data,
    input  logic             flush
);
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [RegAw-1:0] rs1, rs2, rd;

    assign opc = bus.if_instr[6:0];
    assign rd  = bus.if_instr[11:7];
    assign f3  = bus.if_instr[14:12];
    assign rs1 = bus.if_instr[19:15];
    assign rs2 = bus.if_instr[24:20];
    assign f7  = bus.if_instr[31:25];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    logic use1, use2;
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (opc)
            OpcOp, OpcStore:   begin use1 = 1'b1; use2 = 1'b1; end
            OpcOpImm, OpcLoad: use1 = 1'b1;
            default:           ;
        endcase
    end

    // A hit already implies rd != 0, so x0 never matches a producer.
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    assign ex_hit1  = fw_ex_wen && (fw_ex_rd != '0) && (fw_ex_rd == rs1);
    assign ex_hit2  = fw_ex_wen && (fw_ex_rd != '0) && (fw_ex_rd == rs2);
    assign mem_hit1 = fw_mem_wen && (fw_mem_rd != '0) && (fw_mem_rd == rs1);
    assign mem_hit2 = fw_mem_wen && (fw_mem_rd != '0) && (fw_mem_rd == rs2);

    logic            stall;
    logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef DECODE_FORWARD_EN
    assign stall = fw_ex_is_load && ((use1 && ex_hit1) || (use2 && ex_hit2));

    always_comb begin
        if (rs1 == '0)    rs1_val = '0;
        else if (ex_hit1)  rs1_val = fw_ex_data;
        else if (mem_hit1) rs1_val = fw_mem_data;
        else               rs1_val = rf_rs1_data;
        if (rs2 == '0)    rs2_val = '0;
        else if (ex_hit2)  rs2_val = fw_ex_data;
        else if (mem_hit2) rs2_val = fw_mem_data;
        else               rs2_val = rf_rs2_data;
    end
`else
    assign stall = (use1 && (ex_hit1 || mem_hit1)) || (use2 && (ex_hit2 || mem_hit2));
    assign rs1_val = (rs1 == '0) ? '0 : rf_rs1_data;
    assign rs2_val = (rs2 == '0) ? '0 : rf_rs2_data;

    logic unused_fw;
    assign unused_fw = ^{fw_ex_data, fw_mem_data, fw_ex_is_load};
`endif

    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;

    always_comb begin
        case (opc)
            OpcStore:        imm_type = ImmS;
            OpcLui, OpcAuipc: imm_type = ImmU;
            default:         imm_type = ImmI;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (bus.if_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Memory and upper-immediate forms collapse onto an OPIMM add.
    dec_bundle_t dec;
    logic        wen_raw;
    always_comb begin
        dec             = '0;
        dec.opcode      = OpcOpImm;
        dec.funct3      = F3Add;
        dec.funct7      = F7Zero;
        dec.orig_opcode = opc;
        dec.rd          = rd;
        dec.pc          = bus.if_pc;
        wen_raw         = 1'b0;
        case (opc)
            OpcOp: begin
                dec.op1    = rs1_val;
                dec.op2    = rs2_val;
                dec.opcode = OpcOp;
                dec.funct3 = f3;
                dec.funct7 = f7;
                wen_raw    = 1'b1;
            end
            OpcOpImm: begin
                dec.op1    = rs1_val;
                dec.op2    = imm;
                dec.funct3 = f3;
                dec.funct7 = (f3 == F3Sll || f3 == F3Srx) ? f7 : F7Zero;
                wen_raw    = 1'b1;
            end
            OpcLoad: begin
                dec.op1 = rs1_val;
                dec.op2 = imm;
                wen_raw = 1'b1;
            end
            OpcStore: begin
                dec.op1        = rs1_val;
                dec.op2        = imm;
                dec.store_data = rs2_val;
            end
            OpcLui: begin
                dec.op2 = imm;
                wen_raw = 1'b1;
            end
            OpcAuipc: begin
                dec.op1 = bus.if_pc;
                dec.op2 = imm;
                wen_raw = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.wen = wen_raw && (rd != '0);
    end

    logic        valid_q;
    dec_bundle_t bundle_q;
    logic        slot_free, take;

    assign slot_free    = !valid_q || bus.ex_ready;
    assign bus.if_ready = slot_free && !stall && !flush;
    assign take         = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (flush)          valid_q <= 1'b0;
            else if (slot_free) valid_q <= take;
            if (take)           bundle_q <= dec;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_op1         = bundle_q.op1;
    assign bus.ex_op2         = bundle_q.op2;
    assign bus.ex_opcode      = bundle_q.opcode;
    assign bus.ex_funct3      = bundle_q.funct3;
    assign bus.ex_funct7      = bundle_q.funct7;
    assign bus.ex_orig_opcode = bundle_q.orig_opcode;
    assign bus.ex_rd          = bundle_q.rd;
    assign bus.ex_wen         = bundle_q.wen;
    assign bus.ex_store_data  = bundle_q.store_data;
    assign bus.ex_pc          = bundle_q.pc;
    assign bus.ex_illegal     = bundle_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage; the reference model decodes each
// accepted instruction straight from the ISA rules.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        fw_ex_wen, fw_ex_is_load, fw_mem_wen, flush;
    logic [4:0]  fw_ex_rd, fw_mem_rd;
    logic [31:0] fw_ex_data, fw_mem_data;
    logic [31:0] regs [32];

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data),
        .fw_ex_wen     (fw_ex_wen),
        .fw_ex_rd      (fw_ex_rd),
        .fw_ex_data    (fw_ex_data),
        .fw_ex_is_load (fw_ex_is_load),
        .fw_mem_wen    (fw_mem_wen),
        .fw_mem_rd     (fw_mem_rd),
        .fw_mem_data   (fw_mem_data),
        .flush         (flush)
    );

    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [6:0]  orig;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] directed[$] = '{32'h00500093, 32'h4030D113, 32'h002081B3, 32'h0000007F};
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t actual_bundle();
        return {bus.ex_op1, bus.ex_op2, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7,
                bus.ex_orig_opcode, bus.ex_rd, bus.ex_wen, bus.ex_store_data, bus.ex_pc,
                bus.ex_illegal};
    endfunction

    // Architectural value a source register would hold at issue.
    function automatic logic [31:0] src(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef DECODE_FORWARD_EN
        if (fw_ex_wen && fw_ex_rd == r) return fw_ex_data;
        if (fw_mem_wen && fw_mem_rd == r) return fw_mem_data;
`endif
        return regs[r];
    endfunction

    function automatic bit blocked(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef DECODE_FORWARD_EN
        return fw_ex_is_load && fw_ex_wen && fw_ex_rd == r;
`else
        return (fw_ex_wen && fw_ex_rd == r) || (fw_mem_wen && fw_mem_rd == r);
`endif
    endfunction

    function automatic bit hazard(input logic [31:0] ins);
        logic [6:0] opc;
        opc = ins[6:0];
        if (opc == 7'h33 || opc == 7'h23) return blocked(ins[19:15]) || blocked(ins[24:20]);
        if (opc == 7'h13 || opc == 7'h03) return blocked(ins[19:15]);
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] imm_i, imm_s, imm_u;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        w;
        opc   = ins[6:0];
        f3    = ins[14:12];
        imm_i = $signed(ins) >>> 20;
        imm_s = (imm_i & ~32'h1F) | ((ins >> 7) & 32'h1F);
        imm_u = ins & 32'hFFFF_F000;
        e        = '0;
        e.opcode = 7'h13;
        e.orig   = opc;
        e.rd     = ins[11:7];
        e.pc     = pc;
        w        = 1'b0;
        case (opc)
            7'h33: begin
                e.op1 = src(ins[19:15]); e.op2 = src(ins[24:20]); e.opcode = 7'h33;
                e.funct3 = f3; e.funct7 = ins[31:25]; w = 1'b1;
            end
            7'h13: begin
                e.op1 = src(ins[19:15]); e.op2 = imm_i; e.funct3 = f3;
                e.funct7 = (f3 == 3'd1 || f3 == 3'd5) ? ins[31:25] : 7'd0; w = 1'b1;
            end
            7'h03: begin e.op1 = src(ins[19:15]); e.op2 = imm_i; w = 1'b1; end
            7'h23: begin e.op1 = src(ins[19:15]); e.op2 = imm_s; e.sd = src(ins[24:20]); end
            7'h37: begin e.op2 = imm_u; w = 1'b1; end
            7'h17: begin e.op1 = pc; e.op2 = imm_u; w = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        e.wen = w && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [6:0]  f7, bad;
        if (directed.size() != 0) return directed.pop_front();
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        f7  = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        case ($urandom_range(0, 3))
            0:       bad = 7'h7F;
            1:       bad = 7'h63;
            2:       bad = 7'h73;
            default: bad = 7'h0F;
        endcase
        case ($urandom_range(0, 7))
            0, 7:    return {f7, rs2, rs1, f3, rd, 7'h33};
            1:       return {i12, rs1, f3, rd, 7'h13};
            2:       return {i12, rs1, 3'b010, rd, 7'h03};
            3:       return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
            4:       return {u20, rd, 7'h37};
            5:       return {u20, rd, 7'h17};
            default: return {u20, rd, bad};
        endcase
    endfunction

    // Monitor: output must match the oldest outstanding expectation, held while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ex_valid", 192'(bus.ex_valid), 192'(sb.size() != 0));
            if (bus.ex_valid && sb.size() != 0) begin
                check("ex bundle", 192'(actual_bundle()), 192'(sb[0]));
                if (bus.ex_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit   holding, acc, exp_rdy;
        exp_t e;
        rst_n = 1'b0;
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
        flush = 1'b0; fw_ex_wen = 1'b0; fw_ex_rd = '0; fw_ex_data = '0; fw_ex_is_load = 1'b0;
        fw_mem_wen = 1'b0; fw_mem_rd = '0; fw_mem_data = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("reset ex_valid", 192'(bus.ex_valid), 192'(0));
        check("reset ex_opcode", 192'(bus.ex_opcode), 192'(0));
        check("reset ex_wen", 192'(bus.ex_wen), 192'(0));
        check("reset ex_illegal", 192'(bus.ex_illegal), 192'(0));
        check("reset data", 192'({bus.ex_op1, bus.ex_op2, bus.ex_pc, bus.ex_store_data}), 192'(0));
        rst_n = 1'b1;
        holding = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst_n         = 1'b1;
            bus.ex_ready  = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            fw_ex_wen     = 1'($urandom_range(0, 1));
            fw_ex_rd      = 5'($urandom_range(0, 7));
            fw_ex_data    = $urandom;
            fw_ex_is_load = ($urandom_range(0, 2) == 0);
            fw_mem_wen    = 1'($urandom_range(0, 1));
            fw_mem_rd     = 5'($urandom_range(0, 7));
            fw_mem_data   = $urandom;
            regs[$urandom_range(1, 31)] = $urandom;
            if (!holding) begin
                bus.if_valid = ($urandom_range(0, 4) != 0);
                bus.if_instr = gen_instr();
                bus.if_pc    = $urandom & ~32'h3;
            end
            if (cyc == 700 || cyc == 1900) begin
                #1;
                rst_n = 1'b0;
                bus.if_valid = 1'b0;
                #1;
                check("async reset ex_valid", 192'(bus.ex_valid), 192'(0));
                check("async reset outputs",
                      192'({bus.ex_op1, bus.ex_opcode, bus.ex_wen, bus.ex_illegal}), 192'(0));
                sb.delete();
                holding = 1'b0;
                continue;
            end
            #3;
            exp_rdy = (sb.size() == 0 || bus.ex_ready) && !hazard(bus.if_instr) && !flush;
            check("if_ready", 192'(bus.if_ready), 192'(exp_rdy));
            acc = bus.if_valid && exp_rdy;
            if (acc) e = model(bus.if_instr, bus.if_pc);
            #2;
            if (flush) sb.delete();
            if (acc) sb.push_back(e);
            holding = bus.if_valid && !acc && !flush;
        end
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
